// File: rtl/subtractor.sv
// subtractor: handshaked, registered FP_in1 - FP_in2 in fixed or floating point
module subtractor #(
    parameter int ARITH_TYPE = 1,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] FP_in1,
    input  logic [DATA_WIDTH-1:0] FP_in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] FP_out
);

    if (ARITH_TYPE == 1) begin : g_fixed
        logic                  s1_valid_q, s1_valid_d;
        logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
        logic                  out_valid_q, out_valid_d;
        logic [DATA_WIDTH-1:0] fp_out_q, fp_out_d;
        logic                  adv;
        logic                  in_fire;

        // both stages move whenever the output register is empty or draining
        assign adv      = ~out_valid_q | out_ready;
        assign in_ready = reset & adv;
        assign in_fire  = in_valid & in_ready;

        // operand stage feeds the result register; everything holds under backpressure
        always_comb begin
            s1_valid_d  = adv ? in_fire : s1_valid_q;
            a_d         = in_fire ? FP_in1 : a_q;
            b_d         = in_fire ? FP_in2 : b_q;
            out_valid_d = adv ? s1_valid_q : out_valid_q;
            fp_out_d    = (adv & s1_valid_q) ? a_q - b_q : fp_out_q;
        end

        // pipeline registers, cleared by reset
        always_ff @(posedge clk) begin
            if (!reset) begin
                s1_valid_q  <= 1'b0;
                a_q         <= '0;
                b_q         <= '0;
                out_valid_q <= 1'b0;
                fp_out_q    <= '0;
            end else begin
                s1_valid_q  <= s1_valid_d;
                a_q         <= a_d;
                b_q         <= b_d;
                out_valid_q <= out_valid_d;
                fp_out_q    <= fp_out_d;
            end
        end

        assign out_valid = out_valid_q;
        assign FP_out    = fp_out_q;
    end else begin : g_float
        typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, PACK, HOLD} state_t;

        localparam logic [DATA_WIDTH-2:0] INF_MAG = {{E{1'b1}}, {M{1'b0}}};
        localparam logic [DATA_WIDTH-1:0] QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
        localparam logic [E:0]            EMAX    = {1'b0, {E{1'b1}}};
        localparam logic [E:0]            ONE     = (E+1)'(1);
        localparam logic [E:0]            SH_MAX  = (E+1)'(M+1);

        state_t                state_q, state_d;
        logic                  sa_q, sa_d, sb_q, sb_d;
        logic [E:0]            ea_q, ea_d, eb_q, eb_d;
        logic [M:0]            ma_q, ma_d, mb_q, mb_d;
        logic                  spec_q, spec_d, zero_q, zero_d;
        logic [DATA_WIDTH-1:0] spec_val_q, spec_val_d;
        logic                  out_valid_q, out_valid_d;
        logic [DATA_WIDTH-1:0] fp_out_q, fp_out_d;

        logic                  in_fire;
        logic [E-1:0]          a_exp, b_exp;
        logic [M-1:0]          a_man, b_man;
        logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, b_sgn;
        logic                  spec_in;
        logic [DATA_WIDTH-1:0] spec_val_in;
        logic                  a_big;
        logic [E:0]            diff;
        logic [M:0]            small_sh;
        logic [M+1:0]          sum;

        assign in_ready = reset & (state_q == IDLE);
        assign in_fire  = in_valid & in_ready;

        assign a_exp  = FP_in1[DATA_WIDTH-2 -: E];
        assign b_exp  = FP_in2[DATA_WIDTH-2 -: E];
        assign a_man  = FP_in1[M-1:0];
        assign b_man  = FP_in2[M-1:0];
        assign a_zero = a_exp == '0;
        assign b_zero = b_exp == '0;
        assign a_inf  = (&a_exp) & ~(|a_man);
        assign b_inf  = (&b_exp) & ~(|b_man);
        assign a_nan  = (&a_exp) & (|a_man);
        assign b_nan  = (&b_exp) & (|b_man);
        assign b_sgn  = ~FP_in2[DATA_WIDTH-1];

        // special operands resolve at capture; the datapath result is then ignored
        assign spec_in     = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        assign spec_val_in = (a_nan | b_nan) ? QNAN :
                             (a_inf & b_inf) ? ((FP_in1[DATA_WIDTH-1] == FP_in2[DATA_WIDTH-1]) ?
                                                QNAN : {FP_in1[DATA_WIDTH-1], INF_MAG}) :
                             a_inf  ? FP_in1 :
                             b_inf  ? {b_sgn, INF_MAG} :
                             a_zero ? (b_zero ? '0 : {b_sgn, FP_in2[DATA_WIDTH-2:0]}) :
                             FP_in1;

        // alignment: larger magnitude stays, smaller is truncated right by the exponent gap
        assign a_big    = {ea_q, ma_q} >= {eb_q, mb_q};
        assign diff     = a_big ? ea_q - eb_q : eb_q - ea_q;
        assign small_sh = (diff > SH_MAX) ? '0 : (a_big ? mb_q : ma_q) >> diff;

        // magnitudes are ordered, so the difference never goes negative
        assign sum = (sa_q ^ sb_q) ? {1'b0, ma_q} - {1'b0, mb_q} : {1'b0, ma_q} + {1'b0, mb_q};

        // next-state and datapath updates for the multi-cycle float sequence
        always_comb begin
            state_d     = state_q;
            sa_d        = sa_q;
            sb_d        = sb_q;
            ea_d        = ea_q;
            eb_d        = eb_q;
            ma_d        = ma_q;
            mb_d        = mb_q;
            spec_d      = spec_q;
            spec_val_d  = spec_val_q;
            zero_d      = zero_q;
            out_valid_d = out_valid_q;
            fp_out_d    = fp_out_q;
            case (state_q)
                IDLE: if (in_fire) begin
                    sa_d       = FP_in1[DATA_WIDTH-1];
                    sb_d       = b_sgn;
                    ea_d       = {1'b0, a_exp};
                    eb_d       = {1'b0, b_exp};
                    ma_d       = a_zero ? '0 : {1'b1, a_man};
                    mb_d       = b_zero ? '0 : {1'b1, b_man};
                    spec_d     = spec_in;
                    spec_val_d = spec_val_in;
                    zero_d     = 1'b0;
                    state_d    = ALIGN;
                end
                ALIGN: begin
                    sa_d    = a_big ? sa_q : sb_q;
                    sb_d    = a_big ? sb_q : sa_q;
                    ea_d    = a_big ? ea_q : eb_q;
                    ma_d    = a_big ? ma_q : mb_q;
                    mb_d    = small_sh;
                    state_d = SUB;
                end
                SUB: begin
                    zero_d  = sum == '0;
                    sa_d    = (sum == '0) ? 1'b0 : sa_q;
                    ma_d    = sum[M+1] ? sum[M+1:1] : sum[M:0];
                    ea_d    = sum[M+1] ? ea_q + ONE : ea_q;
                    state_d = NORM;
                end
                NORM: begin
                    if (zero_q | spec_q | ma_q[M]) begin
                        state_d = PACK;
                    end else if (ea_q <= ONE) begin
                        zero_d  = 1'b1;
                        state_d = PACK;
                    end else begin
                        ma_d = ma_q << 1;
                        ea_d = ea_q - ONE;
                    end
                end
                PACK: begin
                    fp_out_d    = spec_q ? spec_val_q :
                                  zero_q ? {sa_q, {(DATA_WIDTH-1){1'b0}}} :
                                  (ea_q >= EMAX) ? {sa_q, INF_MAG} :
                                  {sa_q, ea_q[E-1:0], ma_q[M-1:0]};
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // state and datapath registers; reset discards any in-flight operation
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q     <= IDLE;
                sa_q        <= 1'b0;
                sb_q        <= 1'b0;
                ea_q        <= '0;
                eb_q        <= '0;
                ma_q        <= '0;
                mb_q        <= '0;
                spec_q      <= 1'b0;
                spec_val_q  <= '0;
                zero_q      <= 1'b0;
                out_valid_q <= 1'b0;
                fp_out_q    <= '0;
            end else begin
                state_q     <= state_d;
                sa_q        <= sa_d;
                sb_q        <= sb_d;
                ea_q        <= ea_d;
                eb_q        <= eb_d;
                ma_q        <= ma_d;
                mb_q        <= mb_d;
                spec_q      <= spec_d;
                spec_val_q  <= spec_val_d;
                zero_q      <= zero_d;
                out_valid_q <= out_valid_d;
                fp_out_q    <= fp_out_d;
            end
        end

        assign out_valid = out_valid_q;
        assign FP_out    = fp_out_q;
    end

endmodule

// File: doc/subtractor.md
# subtractor

Handshaked, registered operand subtractor computing FP_out = FP_in1 − FP_in2. It is the inverse-direction companion of the combinational adder in the LeNet5 datapath and is used for bias removal and error terms. ARITH_TYPE selects one of two modes:
- two's-complement fixed point, single cycle;
- IEEE-754-style floating point, multi-cycle state machine with one normalization shift per cycle.

## Interface
- ARITH_TYPE, 1, 1 = fixed point, 0 = floating point
- DATA_WIDTH, 32, operand/result width
- E, 8, exponent width (float mode)
- M, 23, mantissa width (float mode); DATA_WIDTH = 1+E+M
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- FP_in1  in  DATA_WIDTH  minuend
- FP_in2  in  DATA_WIDTH  subtrahend
- out_valid  out  1  FP_out valid
- out_ready  in  1  downstream accepts result
- FP_out  out  DATA_WIDTH  difference

## Operation
- Reset (reset=0 at a clock edge):
  - out_valid=0, FP_out=0, state=IDLE.
  - in_ready=0 while reset is low, 1 from the first cycle after release.
  - Any in-flight operation is discarded; no partial result is emitted.
- Accept: in_valid & in_ready at an edge captures both operands.
- Output: out_valid stays high and FP_out stays stable until out_ready & out_valid; then out_valid drops, unless a new result is loaded on the same edge.
- Fixed mode:
  - FP_out = (FP_in1 − FP_in2) mod 2^DATA_WIDTH; wrap, no saturation.
  - in_ready = !out_valid | out_ready, giving full throughput.
- Float mode FSM: IDLE → ALIGN → SUB → NORM → PACK → HOLD → IDLE. in_ready=1 only in IDLE.
  - IDLE: on capture, unpack and invert the sign of FP_in2. Exponent 0 means zero (denormals flush to zero). Append the hidden 1 to get a (M+1)-bit significand.
  - ALIGN: order operands by magnitude; right-shift the smaller significand by the exponent difference in one cycle. A difference > M+1 makes the smaller significand zero. Shifted-out bits are truncated (round toward zero).
  - SUB: add or subtract significands per effective signs into an (M+2)-bit result. Result sign = sign of the larger-magnitude operand.
    - Zero result → +0 (0x00000000), skip NORM.
    - Carry bit set → shift right 1, exponent+1.
  - NORM: while the MSB is clear, shift left one bit and decrement the exponent, one bit per cycle. If the exponent would reach 0, flush the result to signed zero.
  - PACK: assemble {sign, exp, mant} and register FP_out; set out_valid. Exponent reaching all-ones gives ±inf.
  - HOLD: wait for out_ready, then return to IDLE.
- Float special operands, flagged at capture and forced at PACK with no NORM shifts:
  - any NaN → 0x7FC00000;
  - inf − inf of the same sign → 0x7FC00000;
  - inf − finite → inf with its sign;
  - finite − inf → inf with inverted sign;
  - zero operand → other operand (sign-adjusted), or +0 when both are zero.

## Timing
- Fixed mode: capture at edge T, out_valid high after edge T+1.
- Float mode: capture at edge T; ALIGN at T+1, SUB at T+2, NORM check at T+3, plus k extra edges for k left shifts.
  - out_valid high after edge T+4+k.
  - 0 ≤ k ≤ M.
  - Zero and special results always take k=0.
- Back-to-back in float mode: the next capture happens no earlier than the edge after the out handshake.
- Simultaneous in_valid and out handshake:
  - fixed mode: accept, and load the new result on the same edge;
  - float mode: no capture, since in_ready=0 in HOLD.
- Reset low at any edge overrides all other activity.

## Test plan
- Float 0x41A5999A (20.7) − 0x40A80000 (5.25) → FP_out=0x41773334, one NORM shift, out_valid 5 cycles after capture.
- Float 0x40A80000 − 0x40A80000 → 0x00000000, latency 4; 0x3F800000 − 0xBF800000 → 0x40000000 (carry path).
- Fixed 0x00000005 − 0x00000007 → 0xFFFFFFFE; 0x80000000 − 0x00000001 → 0x7FFFFFFF; out_valid one cycle after capture; 8 back-to-back pairs with out_ready=1 → 8 results on consecutive cycles.
- Specials: 0x7F800000 − 0x7F800000 → 0x7FC00000; 0x3F800000 − 0x7F800000 → 0xFF800000; 0x7FC00000 − 0x3F800000 → 0x7FC00000.
- Backpressure: out_ready=0 for 3 cycles after out_valid → FP_out and out_valid stable, in_ready=0 (float) and a second in_valid is ignored. After the handshake the second pair is accepted and produces the correct result.
- Reset low during NORM, then released → out_valid=0 and FP_out=0, no stale result ever appears, and the next operation is correct.
